// File: rtl/drawbridge_pkg.sv
// Shared encodings for the drawbridge controller and its plant model.
//   - FLAT/LIFTING/UPRIGHT/LOWERING: 2-bit controller state codes.
//     The plant takes its motor direction from these codes.
//   - boat_state_e: states of the plant's boat-passage FSM.
package drawbridge_pkg;

  localparam logic [1:0] FLAT     = 2'd0;
  localparam logic [1:0] LIFTING  = 2'd1;
  localparam logic [1:0] UPRIGHT  = 2'd2;
  localparam logic [1:0] LOWERING = 2'd3;

  typedef enum logic [1:0] {
    BoatIdle,
    BoatApproach,
    BoatPassing
  } boat_state_e;

endpackage

// File: rtl/step_tick.sv
// Motor step prescaler.
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-high
//   en    : motor running; a low level discards any partial count
//   tick  : high during the last cycle of every STEP_DIV-cycle period while en is high
module step_tick #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/drawbridge_plant.sv
// Behavioural plant for the DrawBridge controller: turns motor command and
// controller state into bridge position, limit sensors and a boat sensor.
//   Clk, Reset     : clock (rising edge), asynchronous active-high reset
//   MT, State      : motor run command and controller state (sets direction)
//   BoatReq        : one-cycle boat-arrival pulse
//   FaultH         : fault injection, forces H high and L low
//   H, L           : high/low limit sensors (combinational from Angle, FaultH)
//   BS             : boat present
//   Angle          : bridge position, 0 = down, TRAVEL = up
//   Stall          : one-cycle pulse on a step tick that could not move the bridge
//   Collide        : sticky, bridge below full height while a boat was passing
module drawbridge_plant
  import drawbridge_pkg::*;
#(
  parameter int unsigned TRAVEL      = 8,
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned PASS_CYCLES = 6,
  parameter int unsigned AW          = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          MT,
  input  logic [1:0]    State,
  input  logic          BoatReq,
  input  logic          FaultH,
  output logic          H,
  output logic          L,
  output logic          BS,
  output logic [AW-1:0] Angle,
  output logic          Stall,
  output logic          Collide
);

  localparam int unsigned PW = $clog2(PASS_CYCLES + 1);
  localparam logic [AW-1:0] TravelPos = AW'(TRAVEL);
  localparam logic [PW-1:0] PassLoad  = PW'(PASS_CYCLES);

  logic          tick;
  logic [AW-1:0] angle_q, angle_d;
  logic          stall_q, stall_d;
  logic          collide_q, collide_d;
  boat_state_e   boat_q, boat_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          at_top;

  step_tick #(
    .STEP_DIV(STEP_DIV)
  ) u_step_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .en   (MT),
    .tick (tick)
  );

  // True position only; FaultH must not let a boat start passing.
  assign at_top = (angle_q == TravelPos);

  // Position: saturating, one step per tick in the commanded direction.
  always_comb begin
    angle_d = angle_q;
    stall_d = 1'b0;
    if (tick) begin
      if (State == LIFTING && angle_q < TravelPos) begin
        angle_d = angle_q + AW'(1);
      end else if (State == LOWERING && angle_q != '0) begin
        angle_d = angle_q - AW'(1);
      end else begin
        stall_d = 1'b1;
      end
    end
  end

  // Boat passage FSM; BoatReq outside idle is dropped.
  always_comb begin
    boat_d = boat_q;
    pass_d = pass_q;
    unique case (boat_q)
      BoatIdle: begin
        pass_d = '0;
        if (BoatReq) begin
          boat_d = BoatApproach;
        end
      end
      BoatApproach: begin
        if (at_top) begin
          boat_d = BoatPassing;
          pass_d = PassLoad;
        end
      end
      BoatPassing: begin
        if (pass_q == PW'(1)) begin
          boat_d = BoatIdle;
          pass_d = '0;
        end else begin
          pass_d = pass_q - PW'(1);
        end
      end
      default: begin
        boat_d = BoatIdle;
        pass_d = '0;
      end
    endcase
  end

  // Judged on next-state so Collide rises on the same edge the bridge leaves the top.
  always_comb begin
    collide_d = collide_q | ((boat_d == BoatPassing) && (angle_d != TravelPos));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      angle_q   <= '0;
      stall_q   <= 1'b0;
      collide_q <= 1'b0;
      boat_q    <= BoatIdle;
      pass_q    <= '0;
    end else begin
      angle_q   <= angle_d;
      stall_q   <= stall_d;
      collide_q <= collide_d;
      boat_q    <= boat_d;
      pass_q    <= pass_d;
    end
  end

  assign Angle   = angle_q;
  assign Stall   = stall_q;
  assign Collide = collide_q;
  assign BS      = (boat_q != BoatIdle);
  assign H       = at_top | FaultH;
  assign L       = (angle_q == '0) & ~FaultH;

endmodule

// File: tb/tb_drawbridge_plant.sv
// Directed bench for drawbridge_plant with default parameters
// (TRAVEL=8, STEP_DIV=4, PASS_CYCLES=6, AW=4).
module tb_drawbridge_plant;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       MT;
  logic [1:0] State;
  logic       BoatReq;
  logic       FaultH;
  logic       H, L, BS, Stall, Collide;
  logic [3:0] Angle;

  int n_checks = 0;
  int n_fail   = 0;

  drawbridge_plant #(
    .TRAVEL     (8),
    .STEP_DIV   (4),
    .PASS_CYCLES(6),
    .AW         (4)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .MT     (MT),
    .State  (State),
    .BoatReq(BoatReq),
    .FaultH (FaultH),
    .H      (H),
    .L      (L),
    .BS     (BS),
    .Angle  (Angle),
    .Stall  (Stall),
    .Collide(Collide)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; MT = 1'b0; State = 2'd0; BoatReq = 1'b0; FaultH = 1'b0;
    step(2);
    check("rst_angle", 32'(Angle), 0);
    check("rst_h", 32'(H), 0);
    check("rst_l", 32'(L), 1);
    check("rst_bs", 32'(BS), 0);
    check("rst_stall", 32'(Stall), 0);
    check("rst_collide", 32'(Collide), 0);

    // Idle after release: nothing moves.
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_hold", 32'({Angle, H, L, BS}), 32'({4'd0, 1'b0, 1'b1, 1'b0}));
    end

    // Full lift: one step every 4 edges, stall once the top is reached.
    MT = 1'b1; State = 2'd1;
    for (int i = 1; i <= 36; i++) begin
      step(1);
      check("lift_angle", 32'(Angle), (i / 4 > 8) ? 8 : i / 4);
      check("lift_stall", 32'(Stall), (i == 36) ? 1 : 0);
      if (i == 32) begin
        check("lift_top_h", 32'(H), 1);
        check("lift_top_l", 32'(L), 0);
      end
    end

    // Lower with an interrupted step; the partial count must be discarded.
    MT = 1'b0; State = 2'd3;
    step(1);
    MT = 1'b1;
    step(2);
    MT = 1'b0;
    step(4);
    check("lower_abort_hold", 32'(Angle), 8);
    MT = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      step(1);
      check("lower_angle", 32'(Angle), 8 - j / 4);
    end
    check("lower_l", 32'(L), 1);
    check("lower_h", 32'(H), 0);
    MT = 1'b0;
    step(1);

    // Boat arrives at the bottom, bridge lifts, boat passes cleanly.
    BoatReq = 1'b1;
    step(1);
    BoatReq = 1'b0;
    check("boat_bs_rise", 32'(BS), 1);
    MT = 1'b1; State = 2'd1;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      check("boat_bs_lift", 32'(BS), 1);
    end
    check("boat_top", 32'(Angle), 8);
    MT = 1'b0;
    // PASSING entered at the next edge; BS stays 6 cycles, drops on the 7th.
    for (int m = 1; m <= 7; m++) begin
      step(1);
      check("boat_pass_bs", 32'(BS), (m < 7) ? 1 : 0);
    end
    check("boat_no_collide", 32'(Collide), 0);

    // Lowering during passage collides on the edge the bridge leaves the top.
    BoatReq = 1'b1;
    step(1);
    BoatReq = 1'b0;
    step(1);
    MT = 1'b1; State = 2'd3;
    step(3);
    check("col_before", 32'(Collide), 0);
    step(1);
    check("col_angle7", 32'(Angle), 7);
    check("col_set", 32'(Collide), 1);
    step(8);
    check("col_sticky", 32'(Collide), 1);
    check("col_angle5", 32'(Angle), 5);
    MT = 1'b0;

    // Asynchronous reset clears everything without waiting for an edge.
    #2;
    Reset = 1'b1;
    #1;
    check("arst_collide", 32'(Collide), 0);
    check("arst_angle", 32'(Angle), 0);
    check("arst_l", 32'(L), 1);
    step(1);
    Reset = 1'b0;

    // Lift to 3, then fault H while parked in LOWERING.
    MT = 1'b1; State = 2'd1;
    step(12);
    MT = 1'b0; State = 2'd3;
    step(1);
    check("fault_pos", 32'(Angle), 3);
    FaultH = 1'b1;
    #1;
    check("fault_h", 32'(H), 1);
    check("fault_l", 32'(L), 0);
    BoatReq = 1'b1;
    step(1);
    BoatReq = 1'b0;
    check("fault_bs", 32'(BS), 1);
    step(10);
    // Still approaching: a false PASSING at Angle=3 would raise Collide.
    check("fault_bs_hold", 32'(BS), 1);
    check("fault_no_pass", 32'(Collide), 0);
    check("fault_angle", 32'(Angle), 3);
    FaultH = 1'b0;
    #1;
    check("unfault_h", 32'(H), 0);
    check("unfault_l", 32'(L), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/drawbridge_plant.md
# drawbridge_plant

Behavioural plant model of the drawbridge: the responder side of the DrawBridge controller interface. It consumes the controller's motor command (MT) and state, and produces the position sensors (H, L) and the boat sensor (BS) that the controller reads. Benches close the loop by wiring DrawBridge outputs into this block and its sensor outputs back into DrawBridge. CAIN, CAO, MD and PB remain bench-driven.

## Interface
- TRAVEL, 8: position steps from fully down to fully up.
- STEP_DIV, 4: clock cycles per position step while the motor runs. Must be ≥ 1.
- PASS_CYCLES, 6: cycles a boat needs under the raised bridge. Must be ≥ 1.
- AW, 4: width of Angle. Must satisfy 2^AW > TRAVEL.

Ports:
- Clk, in, 1: clock, rising edge.
- Reset, in, 1: asynchronous, active-high.
- MT, in, 1: motor run command from the controller.
- State, in, 2: controller state. Direction is taken from it: LIFTING moves up, LOWERING moves down.
- BoatReq, in, 1: one-cycle pulse meaning a boat arrives.
- FaultH, in, 1: fault injection; forces H high.
- H, out, 1: high-limit sensor.
- L, out, 1: low-limit sensor.
- BS, out, 1: boat present.
- Angle, out, AW: current bridge position.
- Stall, out, 1: one-cycle pulse on an ineffective motor step.
- Collide, out, 1: sticky; bridge left full height while a boat was passing.

## Operation
- State encoding: FLAT=0, LIFTING=1, UPRIGHT=2, LOWERING=3.
- Prescaler (counts 0..STEP_DIV-1):
  - Increments while MT=1.
  - Issues a step tick when it equals STEP_DIV-1, then wraps to 0.
  - Cleared to 0 whenever MT=0.
- On each step tick:
  - LIFTING and Angle<TRAVEL: Angle+1.
  - LOWERING and Angle>0: Angle-1.
  - Any other case (FLAT/UPRIGHT, or already at a limit): Angle holds and Stall=1 for that cycle.
  - Angle saturates; it never wraps.
- Sensor decode from the Angle register:
  - H = (Angle==TRAVEL) | FaultH
  - L = (Angle==0) & ~FaultH
- Boat FSM, states IDLE, APPROACH, PASSING:
  - IDLE: BS=0. BoatReq=1 → APPROACH.
  - APPROACH: BS=1. When Angle==TRAVEL (true position; FaultH ignored) → PASSING, load the pass counter with PASS_CYCLES.
  - PASSING: BS=1. Counter decrements every cycle. When counter==1 → IDLE, so BS drops the next cycle.
  - In PASSING, Angle!=TRAVEL sets Collide=1. Collide stays set until Reset.
- BoatReq is ignored outside IDLE; the model has no queue.
- BoatReq arriving while Angle==TRAVEL: goes to APPROACH, then PASSING one cycle later.

## Timing
- Reset values: Angle=0, H=0, L=1, BS=0, Stall=0, Collide=0, prescaler=0, FSM=IDLE, pass counter=0.
- Reset mid-motion or mid-passage returns everything to the reset values immediately. The bridge is modelled as snapping down.
- Step latency: with MT rising at edge k, the first Angle change occurs at edge k+STEP_DIV. A full lift takes TRAVEL·STEP_DIV cycles.
- H and L change on the same edge as Angle. FaultH reaches H and L combinationally.
- Deasserting MT mid-step discards the partial count. The next step again needs STEP_DIV cycles.
- A State change without MT dropping keeps the prescaler phase. The next tick uses the new direction.
- BS rises one edge after the BoatReq pulse. BS stays high for exactly PASS_CYCLES cycles after entering PASSING.
- Stall pulses once per ineffective tick: every STEP_DIV cycles while the condition persists.

## Structure
- drawbridge_pkg holds:
  - state constants FLAT, LIFTING, UPRIGHT, LOWERING (2-bit)
  - boat FSM state encoding
- The DrawBridge controller imports the same package, so both ends share the encoding.
- One sub-module: step_tick. It is the parameterised prescaler with inputs Clk, Reset, en and output tick.
- Position register, sensor decode and boat FSM live in drawbridge_plant.

## Test plan
- Reset, then release with MT=0 → Angle=0, L=1, H=0, BS=0 held for 20 cycles.
- MT=1, State=1, defaults → Angle increments at edges 4, 8, …, 32. H=1 and L=0 at edge 32. Stall pulses at edge 36.
- From Angle=8, MT=1, State=3; drop MT at cycle 2, raise it again → Angle holds; first decrement 4 cycles after the re-raise. L=1 after 32 running cycles.
- BoatReq pulse at Angle=0, then full lift → BS=1 from the next edge. PASSING starts when Angle hits 8. BS drops exactly 6 cycles later. Collide=0.
- During PASSING, start lowering (State=3, MT=1) → Collide=1 the cycle Angle becomes 7. Collide stays 1 until Reset.
- FaultH=1 at Angle=3 with State=3 → H=1 and L=0 immediately. A BoatReq issued at this point does not enter PASSING.
